// File: rtl/mux_switch_ctrl.sv
// mux_switch_ctrl: applies stream-mux sel/enable changes at packet boundaries (drain, quiesce, switch, settle).
// Optional drain timeout is enabled by defining MUX_SWITCH_TIMEOUT_EN.
module mux_switch_ctrl #(
    parameter int                   SEL_WIDTH      = 3,
    parameter logic [SEL_WIDTH-1:0] DEFAULT_SEL    = '0,
    parameter int                   SETTLE_CYCLES  = 4,
    parameter int                   TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SEL_WIDTH-1:0] req_sel,
    input  logic                 req_enable,
    input  logic                 mon_tvalid,
    input  logic                 mon_tready,
    input  logic                 mon_tlast,
    output logic                 enable,
    output logic                 drop,
    output logic [SEL_WIDTH-1:0] sel,
    output logic [4:0]           gpio,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout
);
    localparam int MAX_CYC = SETTLE_CYCLES > TIMEOUT_CYCLES ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] SET_LD = CW'(SETTLE_CYCLES - 1);
`ifdef MUX_SWITCH_TIMEOUT_EN
    localparam logic [CW-1:0] DRAIN_LD = CW'(TIMEOUT_CYCLES - 1);
`else
    localparam logic [CW-1:0] DRAIN_LD = '0;
`endif
    typedef enum logic [2:0] {IDLE, DRAIN, QUIESCE, SWITCH, SETTLE} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_ld;
    logic [SEL_WIDTH-1:0] lat_sel;
    logic lat_en, in_frame, accept, same, beat, drain_exit, expired;
    assign gpio = {sel, drop, enable};
    assign accept = req_valid & req_ready;
    assign same = req_sel == sel && req_enable == enable;
    assign beat = mon_tvalid & mon_tready;
    // boundary: no open frame and no new mid-frame beat, or the frame closes this cycle
    assign drain_exit = (!in_frame && !(beat && !mon_tlast)) || (beat && mon_tlast);
`ifdef MUX_SWITCH_TIMEOUT_EN
    assign expired = state == DRAIN && cnt == '0 && !drain_exit;
`else
    assign expired = 1'b0;
`endif
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !same) state_nxt = enable ? DRAIN : QUIESCE;
            DRAIN:   if (drain_exit || expired) state_nxt = QUIESCE;
            QUIESCE: if (cnt == '0) state_nxt = SWITCH;
            SWITCH:  state_nxt = SETTLE;
            SETTLE:  if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        cnt_ld = state_nxt == DRAIN ? DRAIN_LD :
                 (state_nxt == QUIESCE || state_nxt == SETTLE) ? SET_LD : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= state_nxt != state ? cnt_ld : (cnt != '0 ? cnt - 1'b1 : cnt);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable    <= 1'b0;
            drop      <= 1'b0;
            sel       <= DEFAULT_SEL;
            in_frame  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            req_ready <= 1'b1;
            lat_sel   <= DEFAULT_SEL;
            lat_en    <= 1'b0;
        end else begin
            busy      <= state_nxt != IDLE;
            req_ready <= state_nxt == IDLE;
            done      <= (state == IDLE && accept && same) || (state == SETTLE && state_nxt == IDLE);
            timeout   <= expired;
            if (expired) in_frame <= 1'b0;
            else if (beat) in_frame <= !mon_tlast;
            if (accept) begin
                lat_sel <= req_sel;
                lat_en  <= req_enable;
            end
            if (state_nxt == QUIESCE && state != QUIESCE) begin
                enable <= 1'b0;
                drop   <= 1'b1;
            end
            if (state == SWITCH) sel <= lat_sel;
            if (state == SETTLE && state_nxt == IDLE) begin
                drop   <= 1'b0;
                enable <= lat_en;
            end
        end
    end
endmodule

// File: tb/tb_mux_switch_ctrl.sv
// tb_mux_switch_ctrl: directed self-checking bench for mux_switch_ctrl (SETTLE_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_mux_switch_ctrl;
    logic clk = 0, rst_n = 0, req_valid = 0, req_enable = 0;
    logic mon_tvalid = 0, mon_tready = 0, mon_tlast = 0;
    logic [2:0] req_sel = 0;
    logic req_ready, enable, drop, busy, done, timeout;
    logic [2:0] sel;
    logic [4:0] gpio;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    mux_switch_ctrl #(.SEL_WIDTH(3), .DEFAULT_SEL(3'd0), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_enable(req_enable), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
        .enable(enable), .drop(drop), .sel(sel), .gpio(gpio), .busy(busy), .done(done), .timeout(timeout)
    );

    task automatic do_req(input logic [2:0] s, input logic e);
        @(negedge clk);
        req_valid = 1; req_sel = s; req_enable = e;
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    task automatic wait_done(output int idx);
        idx = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done) begin idx = i; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (gpio !== 5'b00000) begin n_fail++; $display("FAIL reset_gpio_in_reset: got %b want 00000", gpio); end
        rst_n = 1;
        @(negedge clk);
        n_chk++; if (gpio !== 5'b00000) begin n_fail++; $display("FAIL reset_gpio: got %b want 00000", gpio); end
        n_chk++; if ({enable, drop, sel} !== 5'b00000) begin n_fail++; $display("FAIL reset_outs: got %b want 00000", {enable, drop, sel}); end
        n_chk++; if ({busy, done, timeout, req_ready} !== 4'b0001) begin n_fail++; $display("FAIL reset_status: got %b want 0001", {busy, done, timeout, req_ready}); end
    endtask

    task automatic test_enable_from_idle;
        int drops = 0, dones = 0, sel_at = 0, done_at = 0;
        bit en_early = 0;
        do_req(3'd3, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (drop) drops++;
            if (done) begin dones++; if (done_at == 0) done_at = i; end
            if (sel == 3'd3 && sel_at == 0) sel_at = i;
            if (done_at == 0 && enable) en_early = 1;
        end
        n_chk++; if (drops !== 9) begin n_fail++; $display("FAIL en_drop_cycles: got %0d want 9", drops); end
        n_chk++; if (dones !== 1) begin n_fail++; $display("FAIL en_done_pulses: got %0d want 1", dones); end
        n_chk++; if (done_at !== 10) begin n_fail++; $display("FAIL en_done_latency: got %0d want 10", done_at); end
        n_chk++; if (sel_at !== 6) begin n_fail++; $display("FAIL en_sel_switch: got %0d want 6", sel_at); end
        n_chk++; if (en_early !== 1'b0) begin n_fail++; $display("FAIL en_enable_early: got %b want 0", en_early); end
        n_chk++; if (gpio !== 5'b01101) begin n_fail++; $display("FAIL en_gpio: got %b want 01101", gpio); end
    endtask

    task automatic test_drain_frame;
        bit beat_dis = 0;
        int idx;
        repeat (2) begin
            @(negedge clk);
            mon_tvalid = 1; mon_tready = 1; mon_tlast = 0;
            if (!enable) beat_dis = 1;
        end
        @(negedge clk);
        mon_tvalid = 0;
        do_req(3'd5, 1'b1);
        repeat (6) @(negedge clk);
        n_chk++; if ({busy, enable, drop, req_ready} !== 4'b1100) begin n_fail++; $display("FAIL drain_hold: got %b want 1100", {busy, enable, drop, req_ready}); end
        mon_tvalid = 1; mon_tlast = 1;
        if (!enable) beat_dis = 1;
        @(negedge clk);
        mon_tvalid = 0; mon_tlast = 0;
        n_chk++; if ({enable, drop} !== 2'b01) begin n_fail++; $display("FAIL drain_quiesce: got %b want 01", {enable, drop}); end
        wait_done(idx);
        n_chk++; if (idx !== 9) begin n_fail++; $display("FAIL drain_done_latency: got %0d want 9", idx); end
        n_chk++; if (gpio !== 5'b10101) begin n_fail++; $display("FAIL drain_gpio: got %b want 10101", gpio); end
        n_chk++; if (beat_dis !== 1'b0) begin n_fail++; $display("FAIL drain_beat_disabled: got %b want 0", beat_dis); end
    endtask

    task automatic test_same_req;
        do_req(3'd5, 1'b1);
        @(negedge clk);
        n_chk++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL same_done: got %b want 10", {done, busy}); end
        @(negedge clk);
        n_chk++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL same_after: got %b want 00", {done, busy}); end
        n_chk++; if (gpio !== 5'b10101) begin n_fail++; $display("FAIL same_gpio: got %b want 10101", gpio); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] d1 = 0, d2 = 0;
        int done_at = 0, idx;
        do_req(3'd6, 1'b1);
        for (int i = 1; i <= 20 && done_at == 0; i++) begin
            @(negedge clk);
            if (i == 1) d1 = {enable, drop};
            if (i == 2) d2 = {enable, drop};
            if (done) done_at = i;
        end
        n_chk++; if (d1 !== 2'b10) begin n_fail++; $display("FAIL b2b_drain: got %b want 10", d1); end
        n_chk++; if (d2 !== 2'b01) begin n_fail++; $display("FAIL b2b_quiesce: got %b want 01", d2); end
        n_chk++; if (done_at !== 11) begin n_fail++; $display("FAIL b2b_latency: got %0d want 11", done_at); end
        n_chk++; if ({gpio, req_ready} !== 6'b110011) begin n_fail++; $display("FAIL b2b_gpio1: got %b want 110011", {gpio, req_ready}); end
        req_valid = 1; req_sel = 3'd6; req_enable = 1'b0;
        @(posedge clk);
        #1 req_valid = 0;
        wait_done(idx);
        n_chk++; if (idx !== 11) begin n_fail++; $display("FAIL b2b_disable_latency: got %0d want 11", idx); end
        n_chk++; if (gpio !== 5'b11000) begin n_fail++; $display("FAIL b2b_disable_gpio: got %b want 11000", gpio); end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        do_req(3'd2, 1'b1);
        repeat (7) @(negedge clk);
        n_chk++; if ({busy, drop, sel} !== 5'b11010) begin n_fail++; $display("FAIL rstmid_settle: got %b want 11010", {busy, drop, sel}); end
        rst_n = 0;
        #1;
        n_chk++; if ({gpio, busy, done} !== 7'b0000000) begin n_fail++; $display("FAIL rstmid_outs: got %b want 0000000", {gpio, busy, done}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_chk++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_done: got %0d want 0", dones); end
        n_chk++; if ({req_ready, gpio} !== 6'b100000) begin n_fail++; $display("FAIL rstmid_ready: got %b want 100000", {req_ready, gpio}); end
    endtask

    task automatic test_timeout;
        int idx;
        do_req(3'd1, 1'b1);
        wait_done(idx);
        n_chk++; if (idx !== 10) begin n_fail++; $display("FAIL to_setup_done: got %0d want 10", idx); end
        @(negedge clk);
        mon_tvalid = 1; mon_tready = 1; mon_tlast = 0;
        @(negedge clk);
        mon_tvalid = 0;
        do_req(3'd4, 1'b1);
`ifdef MUX_SWITCH_TIMEOUT_EN
        begin
            int to_at = 0, to_cnt = 0, done_at = 0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (timeout) begin to_cnt++; if (to_at == 0) to_at = i; end
                if (done && done_at == 0) done_at = i;
            end
            n_chk++; if (to_at !== 17) begin n_fail++; $display("FAIL to_pulse_time: got %0d want 17", to_at); end
            n_chk++; if (to_cnt !== 1) begin n_fail++; $display("FAIL to_pulse_count: got %0d want 1", to_cnt); end
            n_chk++; if (done_at !== 26) begin n_fail++; $display("FAIL to_done: got %0d want 26", done_at); end
        end
`else
        begin
            bit to_seen = 0, left = 0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (timeout) to_seen = 1;
                if (!busy || !enable) left = 1;
            end
            n_chk++; if (to_seen !== 1'b0) begin n_fail++; $display("FAIL to_no_pulse: got %b want 0", to_seen); end
            n_chk++; if (left !== 1'b0) begin n_fail++; $display("FAIL to_stay_drain: got %b want 0", left); end
            mon_tvalid = 1; mon_tlast = 1;
            @(negedge clk);
            mon_tvalid = 0; mon_tlast = 0;
            wait_done(idx);
            n_chk++; if (idx !== 9) begin n_fail++; $display("FAIL to_release_done: got %0d want 9", idx); end
        end
`endif
        n_chk++; if (gpio !== 5'b10001) begin n_fail++; $display("FAIL to_gpio: got %b want 10001", gpio); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_enable_from_idle;
        test_drain_frame;
        test_same_req;
        test_back_to_back;
        test_reset_mid;
        test_timeout;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
